// File: rtl/phy_drive_pkg.sv
// ============================================================================
// phy_drive_pkg : shared types and line encoding for the I3C line driver
// Revision 1.0
// ============================================================================
`default_nettype none

package phy_drive_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } drive_state_e;

    typedef struct packed {
        logic value;
        logic pp;
    } line_bit_t;

    // {sel_od_pp, phy_data} with the line released (OD mode, not pulling low)
    localparam logic [1:0] RELEASED = 2'b00;

    function automatic logic [1:0] encode(input line_bit_t b);
        logic [1:0] enc;
        if (b.pp) begin
            enc = {1'b1, b.value};
        end else begin
            enc = {1'b0, ~b.value};
        end
        return enc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phy_drive_ctrl.sv
// ============================================================================
// phy_drive_ctrl : bit-level sequencer for one I3C open-drain/push-pull line
// Revision 1.0
// ============================================================================
`default_nettype none

module phy_drive_ctrl
    import phy_drive_pkg::*;
#(
    parameter int TimingW = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               bit_valid_i,
    output logic               bit_ready_o,
    input  logic               bit_value_i,
    input  logic               bit_pp_i,
    input  logic [TimingW-1:0] t_bit_i,
    input  logic [TimingW-1:0] t_turn_i,
    input  logic               abort_i,
    output logic               phy_data_o,
    output logic               sel_od_pp_o,
    output logic               bit_done_o,
    output logic               busy_o
);

    drive_state_e       state;
    logic [TimingW-1:0] cnt;
    line_bit_t          pend_bit;
    logic [TimingW-1:0] pend_tbit;
    logic               pend_valid;
    logic               last_pp;
    logic               sel_q;
    logic               data_q;

    logic               last_clk;
    logic               handshake;
    logic               needs_turn;
    logic               turn_nonzero;
    logic [TimingW-1:0] tbit_load;
    line_bit_t          req_bit;

    assign last_clk     = (cnt <= TimingW'(1));
    assign turn_nonzero = (t_turn_i != '0);
    assign tbit_load    = (t_bit_i == '0) ? TimingW'(1) : t_bit_i;
    assign req_bit      = '{value: bit_value_i, pp: bit_pp_i};
    assign needs_turn   = last_pp && !bit_pp_i && turn_nonzero;

    assign bit_ready_o  = !abort_i && ((state == IDLE) || ((state == DRIVE) && last_clk));
    assign handshake    = bit_valid_i && bit_ready_o;
    assign bit_done_o   = (state == DRIVE) && last_clk && !abort_i;
    assign busy_o       = (state != IDLE);

    assign sel_od_pp_o  = sel_q;
    assign phy_data_o   = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state             <= IDLE;
            cnt               <= '0;
            pend_bit          <= '0;
            pend_tbit         <= '0;
            pend_valid        <= 1'b0;
            last_pp           <= 1'b0;
            {sel_q, data_q}   <= RELEASED;
        end else if (abort_i) begin
            state             <= IDLE;
            cnt               <= '0;
            pend_bit          <= '0;
            pend_tbit         <= '0;
            pend_valid        <= 1'b0;
            last_pp           <= 1'b0;
            {sel_q, data_q}   <= RELEASED;
        end else if (handshake) begin
            // Only reachable from IDLE or the final DRIVE clock
            if (needs_turn) begin
                state           <= TURN;
                cnt             <= t_turn_i;
                pend_bit        <= req_bit;
                pend_tbit       <= tbit_load;
                pend_valid      <= 1'b1;
                {sel_q, data_q} <= RELEASED;
            end else begin
                state           <= DRIVE;
                cnt             <= tbit_load;
                last_pp         <= bit_pp_i;
                {sel_q, data_q} <= encode(req_bit);
            end
        end else begin
            case (state)
                IDLE: begin
                    {sel_q, data_q} <= RELEASED;
                end
                DRIVE: begin
                    if (!last_clk) begin
                        cnt <= cnt - TimingW'(1);
                    end else if (last_pp && turn_nonzero) begin
                        // A PP high must not be released directly
                        state           <= TURN;
                        cnt             <= t_turn_i;
                        pend_valid      <= 1'b0;
                        {sel_q, data_q} <= RELEASED;
                    end else begin
                        state           <= IDLE;
                        cnt             <= '0;
                        {sel_q, data_q} <= RELEASED;
                    end
                end
                TURN: begin
                    if (!last_clk) begin
                        cnt <= cnt - TimingW'(1);
                    end else if (pend_valid) begin
                        state           <= DRIVE;
                        cnt             <= pend_tbit;
                        last_pp         <= pend_bit.pp;
                        pend_valid      <= 1'b0;
                        {sel_q, data_q} <= encode(pend_bit);
                    end else begin
                        state           <= IDLE;
                        cnt             <= '0;
                        last_pp         <= 1'b0;
                        {sel_q, data_q} <= RELEASED;
                    end
                end
                default: begin
                    state           <= IDLE;
                    cnt             <= '0;
                    pend_valid      <= 1'b0;
                    last_pp         <= 1'b0;
                    {sel_q, data_q} <= RELEASED;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phy_drive_ctrl.sv
// ============================================================================
// tb_phy_drive_ctrl : directed and random checks of phy_drive_ctrl against a
// schedule-queue model of the line. Revision 1.0
// ============================================================================
`default_nettype none

module tb_phy_drive_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       bit_valid_i;
    logic       bit_ready_o;
    logic       bit_value_i;
    logic       bit_pp_i;
    logic [7:0] t_bit_i;
    logic [7:0] t_turn_i;
    logic       abort_i;
    logic       phy_data_o;
    logic       sel_od_pp_o;
    logic       bit_done_o;
    logic       busy_o;

    always #5 clk_i = ~clk_i;

    phy_drive_ctrl #(.TimingW(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .bit_value_i (bit_value_i),
        .bit_pp_i    (bit_pp_i),
        .t_bit_i     (t_bit_i),
        .t_turn_i    (t_turn_i),
        .abort_i     (abort_i),
        .phy_data_o  (phy_data_o),
        .sel_od_pp_o (sel_od_pp_o),
        .bit_done_o  (bit_done_o),
        .busy_o      (busy_o)
    );

    // One entry per future clock of line activity; empty queue means idle/released
    typedef struct packed {
        logic sel;
        logic data;
        logic done;
        logic pp;
    } slot_t;

    slot_t      sched[$];
    logic       m_last_pp;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] obs;   // {sel, data, done, busy, ready}

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_turn(input logic [7:0] n);
        for (int i = 0; i < int'(n); i++) sched.push_back('{sel: 1'b0, data: 1'b0, done: 1'b0, pp: 1'b0});
    endtask

    task automatic push_bit(input logic val, input logic pp, input logic [7:0] tb);
        int n;
        n = (tb == 0) ? 1 : int'(tb);
        for (int i = 0; i < n; i++)
            sched.push_back('{sel: pp, data: (pp ? val : ~val), done: (i == n - 1), pp: pp});
    endtask

    // Drive one clock of inputs, compare outputs with the model, then advance the model
    task automatic cycle(input logic v, input logic val, input logic pp,
                         input logic [7:0] tb, input logic [7:0] tt, input logic ab);
        slot_t cur;
        slot_t e;
        logic  have;
        logic  rdy;
        logic  hs;
        @(negedge clk_i);
        bit_valid_i = v;
        bit_value_i = val;
        bit_pp_i    = pp;
        t_bit_i     = tb;
        t_turn_i    = tt;
        abort_i     = ab;
        #1;
        have = (sched.size() != 0);
        cur  = have ? sched[0] : '0;
        rdy  = !ab && (!have || (sched.size() == 1 && cur.done));
        check("sel",   {7'd0, sel_od_pp_o}, {7'd0, cur.sel});
        check("data",  {7'd0, phy_data_o},  {7'd0, cur.data});
        check("done",  {7'd0, bit_done_o},  {7'd0, cur.done & !ab});
        check("busy",  {7'd0, busy_o},      {7'd0, have});
        check("ready", {7'd0, bit_ready_o}, {7'd0, rdy});
        obs = {sel_od_pp_o, phy_data_o, bit_done_o, busy_o, bit_ready_o};
        hs  = v && rdy;
        if (ab) begin
            sched.delete();
            m_last_pp = 1'b0;
        end else begin
            if (have) begin
                e = sched.pop_front();
                if (e.done && e.pp && !hs && tt != 0) begin
                    push_turn(tt);
                    m_last_pp = 1'b0;
                end
            end
            if (hs) begin
                if (m_last_pp && !pp && tt != 0) push_turn(tt);
                push_bit(val, pp, tb);
                m_last_pp = pp;
            end
        end
    endtask

    task automatic idle_cycle(input logic [7:0] tt);
        cycle(1'b0, 1'b0, 1'b0, 8'd1, tt, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] pat;
        logic [7:0] tb;
        rst_ni      = 1'b0;
        bit_valid_i = 1'b0;
        bit_value_i = 1'b0;
        bit_pp_i    = 1'b0;
        t_bit_i     = 8'd1;
        t_turn_i    = 8'd0;
        abort_i     = 1'b0;
        m_last_pp   = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check("reset_out", {4'd0, sel_od_pp_o, phy_data_o, bit_done_o, busy_o}, 8'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // OD low bit, 4 clocks
        cycle(1'b1, 1'b0, 1'b0, 8'd4, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle_cycle(8'd0);
            check("od_bit", {4'd0, obs[4:1]}, {4'd0, 1'b0, 1'b1, (i == 3), 1'b1});
        end
        idle_cycle(8'd0);
        check("od_end", {3'd0, obs}, 8'b0000_0001);

        // Back-to-back PP 1,0,1 with t_bit=3
        pat = 9'b111000111;
        cycle(1'b1, 1'b1, 1'b1, 8'd3, 8'd0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            cycle((i < 7), (i >= 4 && i < 7), 1'b1, 8'd3, 8'd0, 1'b0);
            check("pp_b2b", {5'd0, obs[4:2]}, {5'd0, 1'b1, pat[9-i], (i % 3 == 0)});
        end
        idle_cycle(8'd0);
        check("pp_b2b_end", {3'd0, obs}, 8'b0000_0001);

        // PP -> OD with t_turn=2, then OD -> PP, then trailing turnaround of 3
        cycle(1'b1, 1'b1, 1'b1, 8'd2, 8'd2, 1'b0);
        idle_cycle(8'd2);
        check("pp_first", {3'd0, obs}, 8'b0001_1010);
        cycle(1'b1, 1'b1, 1'b0, 8'd1, 8'd2, 1'b0);
        check("pp_last", {3'd0, obs}, 8'b0001_1111);
        idle_cycle(8'd2);
        check("turn_1", {3'd0, obs}, 8'b0000_0010);
        idle_cycle(8'd2);
        check("turn_2", {3'd0, obs}, 8'b0000_0010);
        cycle(1'b1, 1'b1, 1'b1, 8'd1, 8'd3, 1'b0);
        check("od_after_turn", {3'd0, obs}, 8'b0000_0111);
        idle_cycle(8'd3);
        check("od_to_pp_nogap", {3'd0, obs}, 8'b0001_1111);
        for (int i = 0; i < 3; i++) begin
            idle_cycle(8'd3);
            check("tail_turn", {3'd0, obs}, 8'b0000_0010);
        end
        idle_cycle(8'd0);
        check("tail_idle", {3'd0, obs}, 8'b0000_0001);

        // Last PP bit with t_turn=0 goes straight to idle
        cycle(1'b1, 1'b1, 1'b1, 8'd1, 8'd0, 1'b0);
        idle_cycle(8'd0);
        check("pp_t0", {3'd0, obs}, 8'b0001_1111);
        idle_cycle(8'd0);
        check("pp_t0_idle", {3'd0, obs}, 8'b0000_0001);

        // Abort on clock 2 of a 5-clock PP bit with a simultaneous request
        cycle(1'b1, 1'b1, 1'b1, 8'd5, 8'd0, 1'b0);
        idle_cycle(8'd0);
        check("abort_pre", {3'd0, obs}, 8'b0001_1010);
        cycle(1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 1'b1);
        check("abort_clk", {3'd0, obs}, 8'b0001_1010);
        idle_cycle(8'd0);
        check("abort_rel", {3'd0, obs}, 8'b0000_0001);
        idle_cycle(8'd0);
        check("abort_drop", {3'd0, obs}, 8'b0000_0001);

        // t_bit=0 acts as a single clock
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        idle_cycle(8'd0);
        check("tbit0", {3'd0, obs}, 8'b0000_1111);
        idle_cycle(8'd0);
        check("tbit0_end", {3'd0, obs}, 8'b0000_0001);

        // Asynchronous reset in the middle of a PP high
        cycle(1'b1, 1'b1, 1'b1, 8'd10, 8'd0, 1'b0);
        idle_cycle(8'd0);
        check("pre_rst", {3'd0, obs}, 8'b0001_1010);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async", {5'd0, sel_od_pp_o, phy_data_o, busy_o}, 8'd0);
        repeat (2) @(negedge clk_i);
        sched.delete();
        m_last_pp = 1'b0;
        rst_ni = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tb = ($urandom_range(0, 63) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  tb, 8'($urandom_range(0, 4)), ($urandom_range(0, 40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
